// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle MEM-stage data memory that stalls the pipeline while WAIT_CYCLES wait states elapse
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   memRead, memWrite   MEM-stage load/store request (store wins when both are high)
//   addr, writeData     byte address and store data, latched when a request is accepted
//   readData            load result; holds between loads
//   readValid           one-cycle pulse in DONE for a completed load
//   memStall            combinational stall back to the pipeline-enable logic
//   misaligned          one-cycle pulse in DONE when the completed request had addr[1:0] != 0
module data_mem_responder #(
  parameter int DEPTH = 256,
  parameter int WAIT_CYCLES = 2,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        readValid,
  output logic        memStall,
  output logic        misaligned
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} stateT;
  stateT             state;
  logic [3:0]        cnt;
  logic              latWrite;
  logic              latMis;
  logic [IDX_W-1:0]  latIdx;
  logic [31:0]       latData;
  logic [31:0]       mem [DEPTH];
  logic              unusedAddr;
  // Upper address bits are ignored, so accesses wrap modulo DEPTH*4.
  assign unusedAddr = ^addr[31:IDX_W+2];
  // Held low during reset; follows the IDLE rule as soon as rst rises.
  assign memStall = rst & (state == IDLE ? (memRead | memWrite) : state == WAIT);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      latWrite   <= 1'b0;
      latMis     <= 1'b0;
      latIdx     <= '0;
      latData    <= '0;
      readData   <= '0;
      readValid  <= 1'b0;
      misaligned <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      readValid  <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        IDLE:
          if (memRead | memWrite) begin
            latWrite <= memWrite;
            latMis   <= |addr[1:0];
            latIdx   <= addr[IDX_W+1:2];
            latData  <= writeData;
            cnt      <= 4'(WAIT_CYCLES - 1);
            state    <= WAIT;
          end
        WAIT:
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            // Misaligned stores are dropped; misaligned loads return zero.
            if (latWrite) begin
              if (!latMis) mem[latIdx] <= latData;
            end else begin
              readData  <= latMis ? '0 : mem[latIdx];
              readValid <= 1'b1;
            end
            misaligned <= latMis;
            state      <= DONE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed vector bench for data_mem_responder
module tb_data_mem_responder;
  localparam int WAIT_CYCLES = 2;
  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] expData;
    logic        expValid;
    logic        expMis;
  } vecT;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memRead = 1'b0, memWrite = 1'b0;
  logic [31:0] addr = '0, writeData = '0;
  logic [31:0] readData;
  logic        readValid, memStall, misaligned;
  logic        memRead2 = 1'b0, memWrite2 = 1'b0;
  logic [31:0] addr2 = '0, writeData2 = '0;
  logic [31:0] readData2;
  logic        readValid2, memStall2, misaligned2;
  int          errors = 0;
  int          checks = 0;
  vecT         vecs[11];
  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite), .addr(addr),
    .writeData(writeData), .readData(readData), .readValid(readValid),
    .memStall(memStall), .misaligned(misaligned)
  );
  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .memRead(memRead2), .memWrite(memWrite2), .addr(addr2),
    .writeData(writeData2), .readData(readData2), .readValid(readValid2),
    .memStall(memStall2), .misaligned(misaligned2)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic runVec(input vecT v, input string tag);
    int n;
    @(negedge clk);
    memRead = v.rd;
    memWrite = v.wr;
    addr = v.a;
    writeData = v.d;
    #1;
    n = 0;
    while (memStall && n < 20) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk({tag, " stallCycles"}, 32'(n), 32'(WAIT_CYCLES + 1));
    chk({tag, " readValid"}, 32'(readValid), 32'(v.expValid));
    chk({tag, " misaligned"}, 32'(misaligned), 32'(v.expMis));
    chk({tag, " readData"}, readData, v.expData);
    memRead = 1'b0;
    memWrite = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, " pulseEnd"}, {30'd0, readValid, misaligned}, 32'd0);
  endtask
  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h21,  32'h1234,     32'hDEADBEEF, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 32'h20,  32'h0,        32'h0,        1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h22,  32'h0,        32'h0,        1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h000, 32'h0,        32'hA5A5A5A5, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 32'h8,   32'h77,       32'hA5A5A5A5, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h8,   32'h0,        32'h77,       1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
    repeat (3) @(negedge clk);
    #1;
    chk("reset readData", readData, 32'h0);
    chk("reset flags", {29'd0, readValid, misaligned, memStall}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("idle after reset", {30'd0, memStall, readValid}, 32'd0);
    end
    for (int i = 0; i < 11; i++) runVec(vecs[i], $sformatf("vec%0d", i));
    begin : readHold
      repeat (5) @(negedge clk);
      #1;
      chk("readData hold", readData, 32'hDEADBEEF);
    end
    begin : midReset
      vecT v;
      @(negedge clk);
      memWrite = 1'b1;
      addr = 32'h4;
      writeData = 32'h55;
      @(negedge clk);
      #1;
      chk("midReset inWait stall", 32'(memStall), 32'd1);
      rst = 1'b0;
      memWrite = 1'b0;
      #1;
      chk("midReset stall", 32'(memStall), 32'd0);
      chk("midReset readData", readData, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      v = '{1'b1, 1'b0, 32'h4, 32'h0, 32'h0, 1'b1, 1'b0};
      runVec(v, "postReset load4");
      v = '{1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0};
      runVec(v, "postReset load10");
    end
    begin : backToBack
      logic [5:0] expStall;
      logic [5:0] expValid;
      expStall = 6'b011011;
      expValid = 6'b100100;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        memRead2 = 1'b1;
        addr2 = (i < 3) ? 32'h0 : 32'h4;
        #1;
        chk($sformatf("b2b stall c%0d", i), 32'(memStall2), 32'(expStall[i]));
        chk($sformatf("b2b valid c%0d", i), 32'(readValid2), 32'(expValid[i]));
      end
      memRead2 = 1'b0;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
